// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// controller state encoding and the ACK read-back layout.
package intc_pkg;

   localparam logic [1:0] ADDR_MASK = 2'd0;
   localparam logic [1:0] ADDR_PEND = 2'd1;
   localparam logic [1:0] ADDR_ACK  = 2'd2;
   localparam logic [1:0] ADDR_EOI  = 2'd3;

   // ACK read-back: in_service flag at the top, vector in the low bits
   localparam int unsigned INSVC_BIT = 31;
   localparam int unsigned VEC_W     = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SERV = 2'd2
   } state_e;

   // Index width for an n-bit request vector, never narrower than one bit
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request bit and whether
// any request is present.
module intc_prio_enc #(
   parameter int unsigned N_SRC = 6,
   parameter int unsigned SEL_W = 3
) (
   input  logic [N_SRC-1:0] req_i,
   output logic [SEL_W-1:0] sel_o,
   output logic             any_o
);

   // Scan upward and keep the first hit so bit 0 has the highest priority
   always_comb begin
      sel_o = '0;
      any_o = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (req_i[i] && !any_o) begin
            sel_o = SEL_W'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/intc.sv
// Interrupt controller: edge-detects each source into a pending register,
// masks it, and hands one request at a time to the CPU through an
// acknowledge / end-of-interrupt handshake.
module intc
   import intc_pkg::*;
#(
   parameter int unsigned N_SRC = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src_i,
   input  logic [1:0]       ADD_I,
   input  logic             WE_I,
   input  logic [31:0]      DAT_I,
   output logic [31:0]      DAT_O,
   output logic             irq_o
);

   localparam int unsigned SEL_W = sel_width(N_SRC);

   logic [N_SRC-1:0] src_q;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] act;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] clr;
   logic [SEL_W-1:0] sel;
   logic             any;
   state_e           state_q;
   logic             irq_q;
   logic [VEC_W-1:0] vec_q;

   logic wr_mask, wr_pend, wr_ack, wr_eoi;
   logic ack_take;
   logic unused_dat;

   assign wr_mask = WE_I && (ADD_I == ADDR_MASK);
   assign wr_pend = WE_I && (ADD_I == ADDR_PEND);
   assign wr_ack  = WE_I && (ADD_I == ADDR_ACK);
   assign wr_eoi  = WE_I && (ADD_I == ADDR_EOI);

   // Only the low N_SRC data bits carry register content
   assign unused_dat = ^DAT_I;

   assign rise = src_i & ~src_q;
   assign act  = pend_q & mask_q;

   intc_prio_enc #(
      .N_SRC (N_SRC),
      .SEL_W (SEL_W)
   ) u_prio_enc (
      .req_i (act),
      .sel_o (sel),
      .any_o (any)
   );

   // An ACK is honoured only in REQ and only while something is still active
   assign ack_take = wr_ack && (state_q == ST_REQ) && any;

   // Next mask/pending: clears from W1C and ACK, new edges always win
   always_comb begin
      mask_d = wr_mask ? DAT_I[N_SRC-1:0] : mask_q;
      clr    = '0;
      if (wr_pend) begin
         clr = DAT_I[N_SRC-1:0];
      end
      if (ack_take) begin
         clr = clr | (N_SRC'(1) << sel);
      end
      pend_d = (pend_q & ~clr) | rise;
   end

   // Source history, mask and pending registers
   always_ff @(posedge clk) begin
      if (reset) begin
         src_q  <= '0;
         mask_q <= '0;
         pend_q <= '0;
      end else begin
         src_q  <= src_i;
         mask_q <= mask_d;
         pend_q <= pend_d;
      end
   end

   // Request handshake FSM with registered irq and captured vector
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         irq_q   <= 1'b0;
         vec_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any) begin
                  state_q <= ST_REQ;
                  irq_q   <= 1'b1;
               end
            end
            ST_REQ: begin
               if (ack_take) begin
                  vec_q   <= VEC_W'(sel);
                  state_q <= ST_SERV;
                  irq_q   <= 1'b0;
               end else if (!any) begin
                  state_q <= ST_IDLE;
                  irq_q   <= 1'b0;
               end
            end
            ST_SERV: begin
               if (wr_eoi) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               irq_q   <= 1'b0;
            end
         endcase
      end
   end

   assign irq_o = irq_q;

   // Register read mux, combinational on the address
   always_comb begin
      DAT_O = '0;
      case (ADD_I)
         ADDR_MASK: DAT_O[N_SRC-1:0] = mask_q;
         ADDR_PEND: DAT_O[N_SRC-1:0] = pend_q;
         ADDR_ACK: begin
            DAT_O[INSVC_BIT]   = (state_q == ST_SERV);
            DAT_O[VEC_W-1:0]   = vec_q;
         end
         default: DAT_O = '0;
      endcase
   end

endmodule
